// File: rtl/i3c_axi_wr_csr_buf.sv
// rtl/i3c_axi_wr_csr_buf.sv - AXI write-beat buffer with CSR window decode and FWFT replay FIFO
module i3c_axi_wr_csr_buf #(
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter int unsigned   UW          = 32,
    parameter int unsigned   IW          = 1,
    parameter int unsigned   DEPTH       = 4,
    parameter logic [AW-1:0] BASE_ADDR   = 32'h0,
    parameter int unsigned   WIN_SIZE    = 32'h1000,
    parameter bit            STRICT_STRB = 1'b1,
    localparam int unsigned  BC          = DW / 8,
    localparam int unsigned  OW          = $clog2(WIN_SIZE),
    localparam int unsigned  LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_dv,
    input  logic [AW-1:0] s_addr,
    input  logic [UW-1:0] s_user,
    input  logic [IW-1:0] s_id,
    input  logic [DW-1:0] s_wdata,
    input  logic [BC-1:0] s_wstrb,
    input  logic [2:0]    s_wsize,
    input  logic          s_last,
    output logic          s_hld,
    output logic          s_err,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [BC-1:0] m_wstrb,
    output logic [IW-1:0] m_id,
    output logic          m_last,
    output logic [LW-1:0] level,
    output logic          idle,
    output logic [7:0]    err_cnt,
    input  logic          err_cnt_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = OW + DW + BC + IW + 1;
    localparam logic [AW:0] L_BASE = {1'b0, BASE_ADDR};
    localparam logic [AW:0] L_WIN  = (AW + 1)'(WIN_SIZE);

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_err_cnt;

    logic [AW:0]   w_off;
    logic          w_bad;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    // Offset computed one bit wider so an address below BASE cannot wrap into the window.
    assign w_off    = {1'b0, s_addr} - L_BASE;
    assign w_bad    = ({1'b0, s_addr} < L_BASE) || (w_off >= L_WIN) ||
                      (STRICT_STRB && (s_wstrb != {BC{1'b1}}));
    assign w_full   = (r_level == LW'(DEPTH));
    assign w_unused = ^{s_user, s_wsize};

    assign s_err  = rst_n && s_dv && w_bad;
    assign s_hld  = rst_n && s_dv && !w_bad && w_full;
    assign w_push = s_dv && !s_hld && !s_err;
    assign w_pop  = m_valid && m_ready;

    assign m_valid = (r_level != '0);
    assign {m_addr, m_wdata, m_wstrb, m_id, m_last} = r_mem[r_rd_ptr];
    assign level   = r_level;
    assign idle    = (r_level == '0) && !s_dv;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_mem[r_wr_ptr] <= {w_off[OW-1:0], s_wdata, s_wstrb, s_id, s_last};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (s_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    always_comb begin
        a_hld_not_err : assert (!(s_hld && s_err));
    end

    a_level_max : assert property (@(posedge clk) disable iff (!rst_n) r_level <= LW'(DEPTH));

    a_m_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> $stable({m_addr, m_wdata, m_wstrb, m_id, m_last}));

    a_no_x : assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({s_hld, s_err, m_valid}));

endmodule

// File: tb/tb_i3c_axi_wr_csr_buf.sv
// tb/tb_i3c_axi_wr_csr_buf.sv - directed scoreboard bench for i3c_axi_wr_csr_buf
module tb_i3c_axi_wr_csr_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_dv;
    logic [31:0] s_addr;
    logic [31:0] s_user;
    logic [0:0]  s_id;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_wsize;
    logic        s_last;
    logic        s_hld;
    logic        s_err;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [0:0]  m_id;
    logic        m_last;
    logic [2:0]  level;
    logic        idle;
    logic [7:0]  err_cnt;
    logic        err_cnt_clr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    i3c_axi_wr_csr_buf dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_dv        (s_dv),
        .s_addr      (s_addr),
        .s_user      (s_user),
        .s_id        (s_id),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wsize     (s_wsize),
        .s_last      (s_last),
        .s_hld       (s_hld),
        .s_err       (s_err),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_id        (m_id),
        .m_last      (m_last),
        .level       (level),
        .idle        (idle),
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_of(input logic [31:0] a, input logic last);
        return {14'h0, a[11:0], a[15:0], ~a[15:0], 4'hF, a[2], last};
    endfunction

    task automatic set_beat(input logic [31:0] a, input logic [3:0] st, input logic last);
        s_dv    = 1'b1;
        s_addr  = a;
        s_wdata = {a[15:0], ~a[15:0]};
        s_wstrb = st;
        s_id    = a[2];
        s_last  = last;
        s_user  = 32'hCAFE_0000 | a;
        s_wsize = 3'd2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for one cycle; called and returns at posedge+1.
    task automatic beat(input logic [31:0] a, input logic [3:0] st, input logic last,
                        input logic e_err, input logic e_hld, input string tag);
        set_beat(a, st, last);
        @(negedge clk);
        chk({tag, "_err"}, 64'(s_err), 64'(e_err));
        chk({tag, "_hld"}, 64'(s_hld), 64'(e_hld));
        if (!e_err && !e_hld) sb.push_back(exp_of(a, last));
        cyc();
        s_dv = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        cyc();
        @(negedge clk);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_level0"}, 64'(level), 64'd0);
        cyc();
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("pop_beat", {14'h0, m_addr, m_wdata, m_wstrb, m_id, m_last}, sb.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_dv = 1'b0; s_addr = '0; s_user = '0; s_id = '0;
        s_wdata = '0; s_wstrb = '0; s_wsize = '0; s_last = 1'b0;
        m_ready = 1'b0; err_cnt_clr = 1'b0;
        cyc();
        cyc();
        set_beat(32'h2000, 4'h1, 1'b1);
        @(negedge clk);
        chk("rst_err_forced", 64'(s_err), 64'd0);
        chk("rst_hld_forced", 64'(s_hld), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_errcnt", 64'(err_cnt), 64'd0);
        cyc();
        s_dv = 1'b0;
        @(negedge clk);
        chk("rst_idle", 64'(idle), 64'd1);
        cyc();
        rst_n = 1'b1;

        // single beat, one-cycle latency, drains straight away
        m_ready = 1'b1;
        beat(32'h10, 4'hF, 1'b1, 1'b0, 1'b0, "t1");
        @(negedge clk);
        chk("t1_mvalid", 64'(m_valid), 64'd1);
        chk("t1_maddr", 64'(m_addr), 64'h10);
        cyc();
        @(negedge clk);
        chk("t1_level0", 64'(level), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        cyc();

        // fill, hold, no same-cycle bypass, then refill and drain in order
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h20 + 32'(4 * i), 4'hF, (i == 3), 1'b0, 1'b0, "t2_fill");
        end
        @(negedge clk);
        chk("t2_level4", 64'(level), 64'd4);
        chk("t2_head_addr", 64'(m_addr), 64'h20);
        cyc();
        set_beat(32'h30, 4'hF, 1'b1);
        @(negedge clk);
        chk("t2_hld_full", 64'(s_hld), 64'd1);
        cyc();
        m_ready = 1'b1;
        @(negedge clk);
        chk("t4_hld_nobypass", 64'(s_hld), 64'd1);
        chk("t4_err_when_hld", 64'(s_err), 64'd0);
        cyc();
        m_ready = 1'b0;
        @(negedge clk);
        chk("t4_hld_release", 64'(s_hld), 64'd0);
        chk("t4_level3", 64'(level), 64'd3);
        sb.push_back(exp_of(32'h30, 1'b1));
        cyc();
        s_dv = 1'b0;
        @(negedge clk);
        chk("t4_level4_again", 64'(level), 64'd4);
        cyc();
        m_ready = 1'b1;
        drain("t2");

        // window and strobe filtering
        beat(32'h1000, 4'hF, 1'b1, 1'b1, 1'b0, "t3_oob");
        @(negedge clk);
        chk("t3_errcnt1", 64'(err_cnt), 64'd1);
        chk("t3_no_push", 64'(level), 64'd0);
        cyc();
        beat(32'h0, 4'h3, 1'b1, 1'b1, 1'b0, "t3_strb");
        @(negedge clk);
        chk("t3_errcnt2", 64'(err_cnt), 64'd2);
        cyc();
        beat(32'h0, 4'h0, 1'b1, 1'b1, 1'b0, "t3_strb0");
        beat(32'hFFFF_FFFC, 4'hF, 1'b0, 1'b1, 1'b0, "t3_high");
        beat(32'hFFC, 4'hF, 1'b0, 1'b0, 1'b0, "t3_edge");
        drain("t3");
        @(negedge clk);
        chk("t3_errcnt4", 64'(err_cnt), 64'd4);
        cyc();

        // saturation and clear priority
        set_beat(32'h2000, 4'hF, 1'b0);
        repeat (300) cyc();
        s_dv = 1'b0;
        @(negedge clk);
        chk("t5_saturate", 64'(err_cnt), 64'd255);
        cyc();
        err_cnt_clr = 1'b1;
        set_beat(32'h2000, 4'hF, 1'b0);
        @(negedge clk);
        chk("t5_err_with_clr", 64'(s_err), 64'd1);
        cyc();
        err_cnt_clr = 1'b0;
        s_dv = 1'b0;
        @(negedge clk);
        chk("t5_clr_wins", 64'(err_cnt), 64'd0);
        cyc();
        beat(32'h3000, 4'hF, 1'b0, 1'b1, 1'b0, "t5_recount");
        @(negedge clk);
        chk("t5_errcnt1", 64'(err_cnt), 64'd1);
        cyc();

        // mid-burst reset discards buffered beats
        m_ready = 1'b0;
        beat(32'h100, 4'hF, 1'b0, 1'b0, 1'b0, "t6_a");
        beat(32'h104, 4'hF, 1'b0, 1'b0, 1'b0, "t6_b");
        beat(32'h108, 4'hF, 1'b0, 1'b0, 1'b0, "t6_c");
        @(negedge clk);
        chk("t6_level3", 64'(level), 64'd3);
        cyc();
        rst_n = 1'b0;
        sb.delete();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_level0", 64'(level), 64'd0);
        chk("t6_mvalid0", 64'(m_valid), 64'd0);
        chk("t6_idle", 64'(idle), 64'd1);
        chk("t6_errcnt0", 64'(err_cnt), 64'd0);
        cyc();
        m_ready = 1'b1;
        beat(32'h4, 4'hF, 1'b1, 1'b0, 1'b0, "t6_post");
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i3c_axi_wr_csr_buf.md
Name: i3c_axi_wr_csr_buf

Overview:
- Buffers component-side write beats from the AXI write subordinate and replays them to the CSR/register-file write port over a valid/ready handshake.
- Decodes the target address window and filters illegal beats, returning a same-cycle err that becomes SLVERR on the AXI B channel.
- Sits directly downstream of the AXI write subordinate and upstream of the I3C CSR block.
- Decouples CSR write stalls from the AXI W channel through a DEPTH-entry FIFO.

Parameters:
- AW, 32, address width, matches subordinate addr.
- DW, 32, data width; BC = DW/8 strobe width.
- UW, 32, user width.
- IW, 1, ID width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- BASE_ADDR, 32'h0, byte base of the CSR window.
- WIN_SIZE, 32'h1000, window size in bytes; power of 2. OW = $clog2(WIN_SIZE).
- STRICT_STRB, 1, when 1 a beat with partial wstrb is an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_dv  in  1  write beat valid from the subordinate.
- s_addr  in  AW  DW-aligned byte address.
- s_user  in  UW  request user; not consumed, ignored.
- s_id  in  IW  transaction ID.
- s_wdata  in  DW  write data.
- s_wstrb  in  BC  byte strobes.
- s_wsize  in  3  AxSIZE; not consumed, ignored.
- s_last  in  1  final beat of the burst.
- s_hld  out  1  stall; the beat is not consumed this cycle.
- s_err  out  1  beat rejected; valid in the same cycle as the beat.
- m_valid  out  1  CSR write request valid.
- m_ready  in  1  CSR accepts the request.
- m_addr  out  OW  window offset (s_addr - BASE_ADDR).
- m_wdata  out  DW  data.
- m_wstrb  out  BC  strobes.
- m_id  out  IW  ID.
- m_last  out  1  last flag.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- idle  out  1  FIFO empty and no beat presented.
- err_cnt  out  8  saturating count of rejected beats.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset is synchronous on clk while rst_n=0:
  - FIFO pointers and level cleared; stored contents are discarded even mid-burst.
  - err_cnt=0; m_valid=0; idle=1.
  - s_hld=0 and s_err=0, forced combinationally while rst_n=0.
- Error decode is purely combinational:
  - bad_addr = (s_addr < BASE_ADDR) || (s_addr - BASE_ADDR >= WIN_SIZE), computed at AW+1 bits so the subtraction does not wrap.
  - bad_strb = STRICT_STRB && (s_wstrb != all-ones). s_wstrb == 0 is also an error when STRICT_STRB=1.
  - s_err = s_dv && (bad_addr || bad_strb).
- Hold:
  - s_hld = s_dv && !s_err && full.
  - full = (level == DEPTH), taken from registered state only. A pop in the same cycle does NOT release hld; this keeps the path to the subordinate free of any combinational m_ready dependency.
  - An errored beat is never held: it is consumed and dropped in one cycle, so the subordinate samples err on the accept edge.
- Push = s_dv && !s_hld && !s_err. It writes {s_addr[OW-1:0] offset, s_wdata, s_wstrb, s_id, s_last} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop and output:
  - Pop = m_valid && m_ready.
  - The FIFO is first-word-fall-through: m_valid = (level != 0), and m_* are driven from the entry at rd_ptr. rd_ptr wraps modulo DEPTH.
  - Latency: a beat pushed in cycle N gives m_valid=1 in cycle N+1 if the FIFO was empty.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. When level == DEPTH, push cannot occur.
  - Pop when empty is impossible because m_valid=0.
- m_* hold stable while m_valid && !m_ready, since only pop advances rd_ptr.
- idle = (level == 0) && !s_dv.
- err_cnt:
  - err_cnt_clr has priority and sets err_cnt=0.
  - Otherwise err_cnt increments on each s_err cycle and saturates at 8'hFF.
  - If clear and error occur in the same cycle, the result is 0.
- Ordering: beats leave in acceptance order and are never reordered or merged across IDs.
- m_last is informational; the CSR block may ignore it.
- Assertions:
  - s_hld implies !s_err.
  - Stability of m_* while m_valid && !m_ready.
  - level <= DEPTH.
  - No known-X on s_hld, s_err, m_valid after reset.

Test Plan:
- Single beat, BASE=0: s_addr=0x10, wstrb=4'hF, m_ready=1 -> s_err=0, s_hld=0; next cycle m_valid=1, m_addr=0x10; level returns to 0.
- 4-beat burst at 0x20, m_ready=0: beats 0-3 push, level=4; a 5th dv gets s_hld=1. Raising m_ready pops in order 0x20, 0x24, 0x28, 0x2C with data intact; hld drops the cycle after level falls to 3.
- s_addr=0x1000 (out of window) -> s_err=1, s_hld=0, no push, err_cnt=1. With STRICT_STRB=1, wstrb=4'h3 -> s_err=1, err_cnt=2.
- Full FIFO with m_ready=1 and dv in the same cycle -> s_hld=1 (no bypass), level goes 4->3; the held beat pushes the next cycle and level returns to 4.
- Drive 300 error beats -> err_cnt saturates at 255. Assert err_cnt_clr together with an error beat -> err_cnt=0.
- Push 3 entries, assert rst_n=0 for 1 cycle -> level=0, m_valid=0, idle=1. A post-reset write at 0x4 emerges alone with m_addr=0x4.
